// File: rtl/fifo_pkg.sv
// Shared helpers for the streaming FIFO: count width and pointer wrap.
// Depths need not be powers of two.
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/streaming_fifo_hwm_if.sv
// AXI-Stream style channel: data, valid, ready.
// Master drives data/valid, slave drives ready.
interface streaming_fifo_hwm_if #(
  parameter int WIDTH = 256
);
  logic [WIDTH-1:0] TDATA;
  logic             TVALID;
  logic             TREADY;

  modport master (
    output TDATA,
    output TVALID,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TVALID,
    output TREADY
  );
endinterface

// File: rtl/streaming_fifo_hwm_mem.sv
// Simple dual-port storage: sync write, async read.
// Kept apart so it can be retargeted to LUTRAM/BRAM.
module streaming_fifo_hwm_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/streaming_fifo_hwm.sv
// AXI-Stream FIFO with occupancy count, almost flags
// and a clearable high-water mark; any depth >= 2.
module streaming_fifo_hwm
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  parameter int CW        = cnt_width(DEPTH)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  streaming_fifo_hwm_if.slave  in0_V_V,
  streaming_fifo_hwm_if.master out_V_V,
  output logic [CW-1:0]        count,
  output logic [CW-1:0]        max_count,
  output logic                 almost_full,
  output logic                 almost_empty,
  input  logic                 clr_max
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  logic [CW-1:0]    next_count;
  logic [CW-1:0]    next_max;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    push       = in0_V_V.TVALID & in_ready;
    pop        = out_valid & out_V_V.TREADY;
    next_count = count;
    unique case (1'b1)
      push & ~pop: next_count = count + CW'(1);
      pop & ~push: next_count = count - CW'(1);
      default: ;
    endcase
    // clr_max reloads live occupancy so the mark never undercuts it
    next_max = (clr_max || next_count > max_count)
             ? next_count : max_count;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      max_count    <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= AW'(ptr_inc(32'(wr_ptr), DEPTH));
      if (pop)
        rd_ptr <= AW'(ptr_inc(32'(rd_ptr), DEPTH));
      count        <= next_count;
      max_count    <= next_max;
      in_ready     <= next_count != CW'(DEPTH);
      out_valid    <= next_count != '0;
      almost_full  <= next_count >= CW'(AFULL_TH);
      almost_empty <= next_count <= CW'(AEMPTY_TH);
    end
  end

  streaming_fifo_hwm_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (ap_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in0_V_V.TDATA),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign in0_V_V.TREADY = in_ready;
  assign out_V_V.TVALID = out_valid;
  assign out_V_V.TDATA  = rd_data;

endmodule

// File: tb/tb_streaming_fifo_hwm.sv
// Self-checking bench for streaming_fifo_hwm (DEPTH=5).
// Scoreboard monitor plus per-scenario tasks.
module tb_streaming_fifo_hwm;

  localparam int W     = 16;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr_max = 1'b0;
  logic [CW-1:0] count;
  logic [CW-1:0] max_count;
  logic          almost_full;
  logic          almost_empty;

  streaming_fifo_hwm_if #(.WIDTH(W)) in_if ();
  streaming_fifo_hwm_if #(.WIDTH(W)) out_if ();

  streaming_fifo_hwm #(
    .WIDTH     (W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AF),
    .AEMPTY_TH (AE)
  ) dut (
    .ap_clk       (clk),
    .ap_rst_n     (rst_n),
    .in0_V_V      (in_if.slave),
    .out_V_V      (out_if.master),
    .count        (count),
    .max_count    (max_count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .clr_max      (clr_max)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mcount = 0;
  int mmax = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  bit mrdy = 1'b0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_d;

  // Scoreboard and occupancy model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      mcount = 0;
      mmax = 0;
      mrdy = 1'b0;
      q.delete();
    end
    checks++;
    if (count !== CW'(mcount)) begin
      errors++;
      $display("FAIL mon_count got=%0d exp=%0d", count, mcount);
    end
    checks++;
    if (max_count !== CW'(mmax)) begin
      errors++;
      $display("FAIL mon_max got=%0d exp=%0d", max_count, mmax);
    end
    checks++;
    if (out_if.TVALID !== (mcount != 0)) begin
      errors++;
      $display("FAIL mon_tvalid got=%b exp=%b", out_if.TVALID, mcount != 0);
    end
    checks++;
    if (in_if.TREADY !== (mrdy && mcount != DEPTH)) begin
      errors++;
      $display("FAIL mon_tready got=%b exp=%b", in_if.TREADY,
               mrdy && mcount != DEPTH);
    end
    checks++;
    if (almost_full !== (mcount >= AF) || almost_empty !== (mcount <= AE)) begin
      errors++;
      $display("FAIL mon_flags got=%b%b exp=%b%b", almost_full, almost_empty,
               mcount >= AF, mcount <= AE);
    end
    if (rst_n) begin
      if (out_if.TVALID && out_if.TREADY) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got=%h exp=none", out_if.TDATA);
        end else begin
          exp_d = q.pop_front();
          if (out_if.TDATA !== exp_d) begin
            errors++;
            $display("FAIL sb_data got=%h exp=%h", out_if.TDATA, exp_d);
          end
        end
        rx_cnt++;
        mcount--;
      end
      if (in_if.TVALID && in_if.TREADY) begin
        q.push_back(in_if.TDATA);
        tx_cnt++;
        mcount++;
      end
      if (clr_max || mcount > mmax) mmax = mcount;
      mrdy = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_if.TVALID = 1'b0;
    in_if.TDATA = '0;
    out_if.TREADY = 1'b0;
    #1 rst_n = 1'b0;
    repeat (5) step();
    checks++;
    if (count !== 0 || max_count !== 0 || out_if.TVALID !== 1'b0 ||
        in_if.TREADY !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got=%0d/%0d/%b/%b/%b exp=0/0/0/0/1",
               count, max_count, out_if.TVALID, in_if.TREADY, almost_empty);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_if.TREADY !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early got=%b exp=0", in_if.TREADY);
    end
    step();
    checks++;
    if (in_if.TREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", in_if.TREADY);
    end
  endtask

  task automatic test_fill_drain();
    int rx0;
    int n;
    out_if.TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_if.TDATA = W'(16'hA0 + i);
      in_if.TVALID = 1'b1;
      step();
      checks++;
      if (count !== CW'(i + 1) || almost_full !== (i + 1 >= AF) ||
          in_if.TREADY !== (i + 1 < DEPTH)) begin
        errors++;
        $display("FAIL fill_%0d got=%0d/%b/%b exp=%0d/%b/%b", i, count,
                 almost_full, in_if.TREADY, i + 1, i + 1 >= AF, i + 1 < DEPTH);
      end
    end
    in_if.TDATA = 16'hA5;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== CW'(5) || in_if.TREADY !== 1'b0) begin
        errors++;
        $display("FAIL full_hold got=%0d/%b exp=5/0", count, in_if.TREADY);
      end
    end
    in_if.TVALID = 1'b0;
    checks++;
    if (out_if.TDATA !== 16'hA0) begin
      errors++;
      $display("FAIL head_word got=%h exp=a0", out_if.TDATA);
    end
    rx0 = rx_cnt;
    out_if.TREADY = 1'b1;
    n = 0;
    while (count != 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (rx_cnt - rx0 != 5 || count !== 0) begin
      errors++;
      $display("FAIL drain got=%0d words exp=5", rx_cnt - rx0);
    end
  endtask

  task automatic test_wrap();
    int rx0;
    int sent;
    int tx_b;
    int cyc;
    rx0 = rx_cnt;
    sent = 0;
    cyc = 0;
    in_if.TVALID = 1'b0;
    while (rx_cnt - rx0 < 23 && cyc < 2000) begin
      if (!in_if.TVALID && sent < 23 && $urandom_range(0, 2) != 0) begin
        in_if.TDATA = W'(16'h3000 + sent);
        in_if.TVALID = 1'b1;
        sent++;
      end
      out_if.TREADY = $urandom_range(0, 2) != 0;
      tx_b = tx_cnt;
      step();
      if (tx_cnt != tx_b) in_if.TVALID = 1'b0;
      cyc++;
      if (count > CW'(DEPTH)) begin
        checks++;
        errors++;
        $display("FAIL wrap_bound got=%0d exp<=5", count);
      end
    end
    in_if.TVALID = 1'b0;
    checks++;
    if (rx_cnt - rx0 != 23 || count !== 0) begin
      errors++;
      $display("FAIL wrap_total got=%0d exp=23", rx_cnt - rx0);
    end
  endtask

  task automatic test_back_to_back();
    int rx0;
    rx0 = rx_cnt;
    out_if.TREADY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_if.TDATA = W'(16'h5000 + i);
      in_if.TVALID = 1'b1;
      step();
      checks++;
      if (count !== CW'(1)) begin
        errors++;
        $display("FAIL b2b_count cyc=%0d got=%0d exp=1", i, count);
      end
    end
    in_if.TVALID = 1'b0;
    step();
    checks++;
    if (rx_cnt - rx0 != 100 || count !== 0) begin
      errors++;
      $display("FAIL b2b_rate got=%0d exp=100", rx_cnt - rx0);
    end
  endtask

  task automatic test_high_water();
    out_if.TREADY = 1'b0;
    clr_max = 1'b1;
    step();
    clr_max = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_if.TDATA = W'(16'h7000 + i);
      in_if.TVALID = 1'b1;
      step();
    end
    in_if.TVALID = 1'b0;
    checks++;
    if (max_count !== CW'(3)) begin
      errors++;
      $display("FAIL hwm_fill got=%0d exp=3", max_count);
    end
    out_if.TREADY = 1'b1;
    repeat (3) step();
    checks++;
    if (max_count !== CW'(3) || count !== 0) begin
      errors++;
      $display("FAIL hwm_keep got=%0d exp=3", max_count);
    end
    clr_max = 1'b1;
    step();
    clr_max = 1'b0;
    checks++;
    if (max_count !== 0) begin
      errors++;
      $display("FAIL hwm_clear got=%0d exp=0", max_count);
    end
    out_if.TREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_if.TDATA = W'(16'h7100 + i);
      in_if.TVALID = 1'b1;
      step();
    end
    in_if.TVALID = 1'b0;
    checks++;
    if (max_count !== CW'(2)) begin
      errors++;
      $display("FAIL hwm_refill got=%0d exp=2", max_count);
    end
    out_if.TREADY = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_mid_reset();
    int n;
    out_if.TREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_if.TDATA = W'(16'hC0 + i);
      in_if.TVALID = 1'b1;
      step();
    end
    in_if.TDATA = 16'hC3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_if.TVALID !== 1'b0 || count !== 0 || in_if.TREADY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got=%b/%0d/%b exp=0/0/0",
               out_if.TVALID, count, in_if.TREADY);
    end
    in_if.TVALID = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    in_if.TDATA = 16'hD0;
    in_if.TVALID = 1'b1;
    step();
    in_if.TDATA = 16'hD1;
    step();
    in_if.TVALID = 1'b0;
    n = 0;
    while (!out_if.TVALID && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (out_if.TVALID !== 1'b1 || out_if.TDATA !== 16'hD0) begin
      errors++;
      $display("FAIL midrst_first got=%b/%h exp=1/d0",
               out_if.TVALID, out_if.TDATA);
    end
    out_if.TREADY = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_high_water();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
